// File: rtl/compression_pkg.sv
// Shared types and constants for the compression side-chain blocks.
package compression_pkg;

    localparam int DATA_W  = 16;   // audio sample width, two's complement
    localparam int SHIFT_W = 4;    // attack/release shift width
    localparam int HOLD_W  = 8;    // hold length / hold counter width
    localparam int THR_W   = 8;    // threshold width (upper byte of a 16-bit level)

    // Largest positive magnitude; also the ceiling of the envelope.
    localparam logic [DATA_W-1:0] MAG_MAX   = 16'h7FFF;
    localparam logic [DATA_W-1:0] DATA_ONE  = 16'd1;
    localparam logic [DATA_W-1:0] DATA_MINV = 16'h8000;
    localparam logic [HOLD_W-1:0] HOLD_ONE  = 8'd1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        HOLD    = 2'd2,
        RELEASE = 2'd3
    } env_state_t;

endpackage

// File: rtl/compression_envelope_if.sv
// Sample stream, control inputs and envelope outputs of the envelope follower.
//
// Handshake: sample_valid is a one-cycle strobe with no ready/backpressure;
// audio_in and the control inputs are taken in the cycle sample_valid is high.
// env_valid is a one-cycle strobe marking the cycle in which env_out,
// over_threshold, env_state and audio_out carry the result of one sample.
// Between strobes those outputs hold their last value.
interface compression_envelope_if;
    import compression_pkg::*;

    logic                    sample_valid;
    logic [DATA_W-1:0]       audio_in;
    logic [THR_W-1:0]        threshold;
    logic [SHIFT_W-1:0]      attack_shift;
    logic [SHIFT_W-1:0]      release_shift;
    logic [HOLD_W-1:0]       hold_len;

    logic [DATA_W-1:0]       audio_out;
    logic [DATA_W-1:0]       env_out;
    logic                    env_valid;
    logic                    over_threshold;
    env_state_t              env_state;

    modport master (
        output sample_valid, audio_in, threshold, attack_shift, release_shift, hold_len,
        input  audio_out, env_out, env_valid, over_threshold, env_state
    );

    modport slave (
        input  sample_valid, audio_in, threshold, attack_shift, release_shift, hold_len,
        output audio_out, env_out, env_valid, over_threshold, env_state
    );

endinterface

// File: rtl/compression_abs_sat.sv
// Combinational saturating magnitude: |x|, with the most negative value
// clamped to MAG_MAX so the result always fits the positive range.
module compression_abs_sat
    import compression_pkg::*;
(
    input  logic [DATA_W-1:0] x_i,
    output logic [DATA_W-1:0] mag_o
);

    // Negate negative samples; -32768 has no positive twin, so clamp it.
    always_comb begin
        mag_o = x_i;
        if (x_i[DATA_W-1]) begin
            if (x_i == DATA_MINV) begin
                mag_o = MAG_MAX;
            end else begin
                mag_o = ~x_i + DATA_ONE;
            end
        end
    end

endmodule

// File: rtl/compression_envelope.sv
// Peak envelope follower with attack / hold / release.
// S1 registers the saturated magnitude, the raw sample and the controls;
// S2 updates the envelope and FSM and strobes env_valid. Latency is 2 clk.
module compression_envelope
    import compression_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    compression_envelope_if.slave   bus
);

    // ---------------- S1 ----------------
    logic [DATA_W-1:0]  mag_w;

    logic               s1_valid_q;
    logic [DATA_W-1:0]  s1_mag_q;
    logic [DATA_W-1:0]  s1_audio_q;
    logic [THR_W-1:0]   s1_thr_q;
    logic [SHIFT_W-1:0] s1_atk_q;
    logic [SHIFT_W-1:0] s1_rel_q;
    logic [HOLD_W-1:0]  s1_hold_q;

    compression_abs_sat u_abs (
        .x_i   (bus.audio_in),
        .mag_o (mag_w)
    );

    // Capture each sample together with the controls that apply to it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_mag_q   <= '0;
            s1_audio_q <= '0;
            s1_thr_q   <= '0;
            s1_atk_q   <= '0;
            s1_rel_q   <= '0;
            s1_hold_q  <= '0;
        end else begin
            s1_valid_q <= bus.sample_valid;
            if (bus.sample_valid) begin
                s1_mag_q   <= mag_w;
                s1_audio_q <= bus.audio_in;
                s1_thr_q   <= bus.threshold;
                s1_atk_q   <= bus.attack_shift;
                s1_rel_q   <= bus.release_shift;
                s1_hold_q  <= bus.hold_len;
            end
        end
    end

    // ---------------- S2 ----------------
    env_state_t         state_q, state_d;
    logic [DATA_W-1:0]  env_q, env_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic               env_valid_q;
    logic               over_q, over_d;
    logic [DATA_W-1:0]  audio_out_q;

    logic [DATA_W-1:0]  thr16;
    logic [DATA_W-1:0]  rise_step, env_rise;
    logic [DATA_W-1:0]  fall_step, env_fall;

    // Candidate rise/decay values; the step is at least 1 so the envelope
    // always converges, and never larger than the gap so it cannot overshoot mag.
    always_comb begin
        thr16     = {s1_thr_q, 8'b0};
        rise_step = (s1_mag_q - env_q) >> s1_atk_q;
        if (rise_step == '0) begin
            rise_step = DATA_ONE;
        end
        env_rise  = env_q + rise_step;
        fall_step = (env_q - s1_mag_q) >> s1_rel_q;
        if (fall_step == '0) begin
            fall_step = DATA_ONE;
        end
        env_fall  = env_q;
        if (env_q > s1_mag_q) begin
            env_fall = env_q - fall_step;
        end
    end

    // Next-state logic; only S1-valid cycles advance env, state and hold counter.
    always_comb begin
        state_d    = state_q;
        env_d      = env_q;
        hold_cnt_d = hold_cnt_q;
        if (s1_valid_q) begin
            if (s1_mag_q > env_q) begin
                env_d   = env_rise;
                state_d = ATTACK;
            end else begin
                case (state_q)
                    ATTACK: begin
                        if (s1_hold_q == '0) begin
                            env_d      = env_fall;
                            hold_cnt_d = '0;
                            state_d    = RELEASE;
                        end else begin
                            hold_cnt_d = s1_hold_q;
                            state_d    = HOLD;
                        end
                    end
                    HOLD: begin
                        if (hold_cnt_q <= HOLD_ONE) begin
                            hold_cnt_d = '0;
                            state_d    = RELEASE;
                        end else begin
                            hold_cnt_d = hold_cnt_q - HOLD_ONE;
                        end
                    end
                    RELEASE: begin
                        env_d = env_fall;
                        if (env_fall < thr16) begin
                            state_d = IDLE;
                        end
                    end
                    default: begin
                        env_d = env_fall;
                    end
                endcase
            end
        end
        over_d = (env_d >= thr16);
    end

    // S2 state and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            env_q       <= '0;
            hold_cnt_q  <= '0;
            env_valid_q <= 1'b0;
            over_q      <= 1'b0;
            audio_out_q <= '0;
        end else begin
            env_valid_q <= s1_valid_q;
            state_q     <= state_d;
            env_q       <= env_d;
            hold_cnt_q  <= hold_cnt_d;
            if (s1_valid_q) begin
                over_q      <= over_d;
                audio_out_q <= s1_audio_q;
            end
        end
    end

    assign bus.env_out        = env_q;
    assign bus.env_valid      = env_valid_q;
    assign bus.over_threshold = over_q;
    assign bus.audio_out      = audio_out_q;
    assign bus.env_state      = state_q;

endmodule
